// File: rtl/aes_inv_key_expand_128.sv
// Iterative AES-128 inverse key schedule: loads the round-10 key, then steps down one round key per clock to round 0.
// Latency: 10 cycles from the load edge to the original key. No backpressure: the schedule free-runs after kld.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] d
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; zero maps to zero.
    always_comb begin
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        d = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_inv_key_expand_128 (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key,
    output logic [31:0]  wo_0,
    output logic [31:0]  wo_1,
    output logic [31:0]  wo_2,
    output logic [31:0]  wo_3,
    output logic [3:0]   rnd,
    output logic         busy,
    output logic         done
);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] n0, n1, n2, n3;
    logic [31:0] rot;
    logic [31:0] sub;
    logic [7:0]  rcon;

    assign n3  = w3 ^ w2;
    assign n2  = w2 ^ w1;
    assign n1  = w1 ^ w0;
    assign rot = {n3[23:0], n3[31:24]};

    aes_sbox u_sbox_0 (.a(rot[31:24]), .d(sub[31:24]));
    aes_sbox u_sbox_1 (.a(rot[23:16]), .d(sub[23:16]));
    aes_sbox u_sbox_2 (.a(rot[15:8]),  .d(sub[15:8]));
    aes_sbox u_sbox_3 (.a(rot[7:0]),   .d(sub[7:0]));

    // Rcon indexed by the round being stepped away from.
    always_comb begin
        case (rnd)
            4'd10:   rcon = 8'h36;
            4'd9:    rcon = 8'h1b;
            4'd8:    rcon = 8'h80;
            4'd7:    rcon = 8'h40;
            4'd6:    rcon = 8'h20;
            4'd5:    rcon = 8'h10;
            4'd4:    rcon = 8'h08;
            4'd3:    rcon = 8'h04;
            4'd2:    rcon = 8'h02;
            4'd1:    rcon = 8'h01;
            default: rcon = 8'h00;
        endcase
    end

    assign n0 = w0 ^ sub ^ {rcon, 24'h000000};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w0   <= 32'h0;
            w1   <= 32'h0;
            w2   <= 32'h0;
            w3   <= 32'h0;
            rnd  <= 4'd0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (kld) begin
            w0   <= key[127:96];
            w1   <= key[95:64];
            w2   <= key[63:32];
            w3   <= key[31:0];
            rnd  <= 4'd10;
            busy <= 1'b1;
            done <= 1'b0;
        end else if (busy) begin
            w0  <= n0;
            w1  <= n1;
            w2  <= n2;
            w3  <= n3;
            rnd <= rnd - 4'd1;
            if (rnd == 4'd1) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    assign wo_0 = w0;
    assign wo_1 = w1;
    assign wo_2 = w2;
    assign wo_3 = w3;
endmodule
